timex_port_sequencer: RTL
=========================

TIMEX_PORT_SEQUENCER -- requirements
Module: timex_port_sequencer

Interface
REQ-001 Parameter STROBE_CYCLES, default 4: CLK cycles for which LS273 is held high per port write (legal range 1..15).
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of the bus-strobe synchronisers (legal range 2..3).
REQ-003 Port CLK  input  1: single system clock; all state changes on its rising edge.
REQ-004 Port RST  input  1: asynchronous, active-high reset.
REQ-005 Port A  input  16: Z80 address bus.
REQ-006 Ports nIORQ, nMREQ, nRD, nWR, nM1  input  1 each: Z80 strobes, active low, asynchronous to CLK.
REQ-007 Port nZX_ROMCS  output  1: high disables the Spectrum internal ROM, and equals the paged state.
REQ-008 Port nROM_CS  output  1: interface 4 KB ROM select, active low.
REQ-009 Port nRAM_CS  output  1: interface 2 KB RAM select, active low.
REQ-010 Port LS273  output  1: port-0xEF write latch strobe, active high, registered.
REQ-011 Port nLS244  output  1: port-0xEF read buffer enable, active low, registered.
REQ-012 Port nWAIT  output  1: Z80 wait request, active low, registered, open-drain at board level.
REQ-013 Port paged  output  1: paged-in status, registered.

Function
REQ-014 nIORQ, nMREQ, nRD, nWR and nM1 SHALL each pass through a SYNC_STAGES synchroniser; A SHALL be sampled unsynchronised only on the CLK edge where a synchronised strobe falls.
REQ-015 A port hit SHALL be: synchronised nIORQ falls, A[7:0]=0xEF and synchronised nM1 is high; an IORQ with M1 low (interrupt acknowledge) SHALL be ignored.
REQ-016 The port FSM states SHALL be IDLE, WR_STROBE, WR_HOLD, RD_ACTIVE and WAIT_END.
REQ-017 On a port hit with synchronised nWR low, the FSM SHALL go IDLE->WR_STROBE, drive LS273=1 for exactly STROBE_CYCLES cycles (4-bit down-counter), then go to WR_HOLD.
REQ-018 nWAIT SHALL be 0 from the cycle after a write hit until the cycle LS273 returns to 0, so that the Z80 cycle cannot end before the latch strobe completes.
REQ-019 WR_HOLD SHALL return to IDLE when synchronised nIORQ is high.
REQ-020 On a port hit with synchronised nRD low, the FSM SHALL enter RD_ACTIVE with nLS244=0 from the next cycle, and hold it until synchronised nRD or nIORQ goes high, then return to IDLE; nWAIT SHALL stay 1 during reads.
REQ-021 A hit with both nRD and nWR low SHALL be treated as illegal: the FSM SHALL enter WAIT_END with no strobe and leave it when nIORQ goes high.
REQ-022 Page-in candidate: synchronised nMREQ falls with nM1 low, nRD low and A=0x0000 or 0x0008; page-out candidate: nMREQ falls with nRD low and A=0x0604.
REQ-023 The candidate SHALL be latched at the nMREQ fall and applied to paged on the rising edge of synchronised nMREQ (end of cycle), so the triggering fetch completes from the old ROM.
REQ-024 Page-in and page-out candidates are mutually exclusive by address; a new nMREQ fall SHALL overwrite any pending, not-yet-applied candidate.
REQ-025 nZX_ROMCS SHALL equal paged.
REQ-026 nROM_CS SHALL be combinational: 0 when paged=1, nMREQ=0 and A[15:13]=000.
REQ-027 nRAM_CS SHALL be combinational: 0 when paged=1, nMREQ=0 and A[15:13]=001 (0x2000-0x27FF is decoded via board-level A11 gating; the CPLD does not decode A11).
REQ-028 Port decode SHALL be independent of paged.

Reset
REQ-029 RST=1 SHALL immediately force: FSM IDLE, counter 0, LS273=0, nLS244=1, nWAIT=1, paged=0, pending candidate cleared, synchroniser flops=1.
REQ-030 Reset asserted mid-strobe SHALL truncate LS273 and release nWAIT asynchronously, with no resumption after release.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration, port address 0xEF, page-in addresses 0x0000 and 0x0008, page-out address 0x0604, and the ROM/RAM A[15:13] codes.
REQ-032 One sub-module, strobe_sync (parameterised depth, reset value 1), SHALL be instantiated per Z80 strobe.

Verification
REQ-033 Write 0xEF with STROBE_CYCLES=4 -> LS273 high for exactly 4 CLK cycles, nWAIT low throughout and high the cycle LS273 falls, FSM IDLE after nIORQ rises.
REQ-034 Read 0xEF -> nLS244 low starting SYNC_STAGES+1 cycles after nIORQ/nRD fall, high within SYNC_STAGES+1 cycles of nRD rise; nWAIT stays 1.
REQ-035 M1 fetch at 0x0008 -> paged and nZX_ROMCS stay 0 during that cycle and go 1 after nMREQ rises; a following read at 0x0100 -> nROM_CS=0; a read at 0x2010 -> nRAM_CS=0.
REQ-036 Read at 0x0604 while paged -> paged=0 after nMREQ rises; a non-M1 read at 0x0000 -> no page-in.
REQ-037 Interrupt acknowledge (nIORQ and nM1 low, A[7:0]=0xEF) -> no LS273, no nLS244, no nWAIT.
REQ-038 RST pulse during the 2nd LS273 cycle -> LS273=0, nWAIT=1 and paged=0 immediately; no strobe after RST falls.

Source files
------------

// File: rtl/timex_port_sequencer_pkg.sv
// Shared constants for the Timex-style port/paging sequencer: FSM states,
// decoded bus addresses and ROM/RAM A[15:13] window codes.
package timex_port_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_STROBE = 3'd1,
    ST_WR_HOLD   = 3'd2,
    ST_RD_ACTIVE = 3'd3,
    ST_WAIT_END  = 3'd4
  } port_state_t;

  localparam logic [7:0]  PORT_ADDR     = 8'hEF;
  localparam logic [15:0] PAGE_IN_ADDR0 = 16'h0000;
  localparam logic [15:0] PAGE_IN_ADDR1 = 16'h0008;
  localparam logic [15:0] PAGE_OUT_ADDR = 16'h0604;
  localparam logic [2:0]  ROM_A_CODE    = 3'b000;
  localparam logic [2:0]  RAM_A_CODE    = 3'b001;

  function automatic logic is_page_in_addr(input logic [15:0] a);
    return (a == PAGE_IN_ADDR0) || (a == PAGE_IN_ADDR1);
  endfunction

endpackage

// File: rtl/timex_port_sequencer_strobe_sync.sv
// Multi-flop synchroniser for one active-low Z80 strobe; resets to the
// inactive (high) level.
module strobe_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '1;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/timex_port_sequencer.sv
// Port 0xEF latch/buffer sequencer with nWAIT stretching, plus ROM paging
// triggered by fetches at 0x0000/0x0008 and released by a read at 0x0604.
module timex_port_sequencer
  import timex_port_sequencer_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] A,
  input  logic        nIORQ,
  input  logic        nMREQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  output logic        nZX_ROMCS,
  output logic        nROM_CS,
  output logic        nRAM_CS,
  output logic        LS273,
  output logic        nLS244,
  output logic        nWAIT,
  output logic        paged
);

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES);
  localparam logic [2:0] FLUSH_DONE  = 3'(SYNC_STAGES + 1);

  logic w_iorq_s, w_mreq_s, w_rd_s, w_wr_s, w_m1_s;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_iorq (.i_clk(CLK), .i_rst(RST), .i_d(nIORQ), .o_q(w_iorq_s));
  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_mreq (.i_clk(CLK), .i_rst(RST), .i_d(nMREQ), .o_q(w_mreq_s));
  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_rd   (.i_clk(CLK), .i_rst(RST), .i_d(nRD),   .o_q(w_rd_s));
  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_wr   (.i_clk(CLK), .i_rst(RST), .i_d(nWR),   .o_q(w_wr_s));
  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_m1   (.i_clk(CLK), .i_rst(RST), .i_d(nM1),   .o_q(w_m1_s));

  logic       r_iorq_d, r_mreq_d;
  logic [2:0] r_flush;
  logic       w_live;

  // Edges are ignored until the synchronisers hold real bus samples, so a
  // strobe still low when reset releases does not restart a transaction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_iorq_d <= 1'b1;
      r_mreq_d <= 1'b1;
      r_flush  <= '0;
    end else begin
      r_iorq_d <= w_iorq_s;
      r_mreq_d <= w_mreq_s;
      if (r_flush != FLUSH_DONE) r_flush <= r_flush + 3'd1;
    end
  end

  assign w_live = (r_flush == FLUSH_DONE);

  logic w_iorq_fall, w_mreq_fall, w_mreq_rise, w_port_hit;
  logic w_cand_in, w_cand_out;

  assign w_iorq_fall = w_live & r_iorq_d & ~w_iorq_s;
  assign w_mreq_fall = w_live & r_mreq_d & ~w_mreq_s;
  assign w_mreq_rise = w_live & ~r_mreq_d & w_mreq_s;
  assign w_port_hit  = w_iorq_fall & (A[7:0] == PORT_ADDR) & w_m1_s;
  assign w_cand_in   = ~w_m1_s & ~w_rd_s & is_page_in_addr(A);
  assign w_cand_out  = ~w_rd_s & (A == PAGE_OUT_ADDR);

  port_state_t r_state;
  logic [3:0]  r_cnt;
  logic        r_ls273, r_nls244, r_nwait;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ls273  <= 1'b0;
      r_nls244 <= 1'b1;
      r_nwait  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_port_hit) begin
            if (!w_rd_s && !w_wr_s) begin
              r_state <= ST_WAIT_END;
            end else if (!w_wr_s) begin
              r_state <= ST_WR_STROBE;
              r_cnt   <= STROBE_LOAD;
              r_ls273 <= 1'b1;
              r_nwait <= 1'b0;
            end else if (!w_rd_s) begin
              r_state  <= ST_RD_ACTIVE;
              r_nls244 <= 1'b0;
            end
          end
        end
        ST_WR_STROBE: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= '0;
            r_ls273 <= 1'b0;
            r_nwait <= 1'b1;
            r_state <= ST_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_WR_HOLD: begin
          if (w_iorq_s) r_state <= ST_IDLE;
        end
        ST_RD_ACTIVE: begin
          if (w_rd_s || w_iorq_s) begin
            r_nls244 <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        ST_WAIT_END: begin
          if (w_iorq_s) r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_ls273  <= 1'b0;
          r_nls244 <= 1'b1;
          r_nwait  <= 1'b1;
        end
      endcase
    end
  end

  logic r_pend_in, r_pend_out, r_paged;

  // Candidate captured at the MREQ fall, committed at its rise so the
  // triggering fetch still completes from the previously selected ROM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend_in  <= 1'b0;
      r_pend_out <= 1'b0;
      r_paged    <= 1'b0;
    end else if (w_mreq_fall) begin
      r_pend_in  <= w_cand_in;
      r_pend_out <= w_cand_out;
    end else if (w_mreq_rise) begin
      if (r_pend_in)       r_paged <= 1'b1;
      else if (r_pend_out) r_paged <= 1'b0;
      r_pend_in  <= 1'b0;
      r_pend_out <= 1'b0;
    end
  end

  assign LS273     = r_ls273;
  assign nLS244    = r_nls244;
  assign nWAIT     = r_nwait;
  assign paged     = r_paged;
  assign nZX_ROMCS = r_paged;
  assign nROM_CS   = ~(r_paged & ~nMREQ & (A[15:13] == ROM_A_CODE));
  assign nRAM_CS   = ~(r_paged & ~nMREQ & (A[15:13] == RAM_A_CODE));

endmodule
